// File: rtl/four_value_sorter.sv
// Sequential bubble sorter for four 4-bit values.
// One shared magnitude comparator, one compare-swap per clock, early exit.
module mag_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

module four_value_sorter #(
  parameter bit DESCEND = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic [2:0]  swap_count
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_SORT,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] elem [4];
  logic [1:0] pass;
  logic [1:0] j;
  logic [1:0] j_nx;
  logic       flag;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       gt;
  logic       eq;
  logic       lt;
  logic       swap;
  logic       last;
  logic       finish;

  assign j_nx = j + 2'd1;
  assign op_a = elem[j];
  assign op_b = elem[j_nx];

  mag_cmp4 u_cmp (
    .a  (op_a),
    .b  (op_b),
    .gt (gt),
    .eq (eq),
    .lt (lt)
  );

  // equal pairs never swap, keeping the sort stable
  assign swap = (state == S_SORT) && !eq && (DESCEND ? lt : gt);
  assign last = (j == (2'd2 - pass));
  assign finish = last && (!(flag || swap) || (pass == 2'd2));

  assign dout = {elem[3], elem[2], elem[1], elem[0]};

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_SORT;
      S_SORT: if (finish) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      swap_count <= '0;
      pass       <= '0;
      j          <= '0;
      flag       <= 1'b0;
      for (int i = 0; i < 4; i++) elem[i] <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state == S_SORT) && finish;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 4; i++) elem[i] <= din[4*i +: 4];
            swap_count <= '0;
            flag       <= 1'b0;
            pass       <= '0;
            j          <= '0;
          end
        end
        S_SORT: begin
          if (swap) begin
            elem[j]    <= op_b;
            elem[j_nx] <= op_a;
            swap_count <= swap_count + 3'd1;
          end
          if (last) begin
            j    <= '0;
            flag <= 1'b0;
            if (!finish) pass <= pass + 2'd1;
          end else begin
            j    <= j_nx;
            flag <= flag || swap;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_four_value_sorter.sv
// Scoreboard bench for four_value_sorter, ascending and descending instances.
// Reference: sorted queue, inversion count, and max-left-inversion pass count.
module tb_four_value_sorter;
  typedef struct {
    logic [15:0] dout;
    int          sc;
    int          n;
    int          k;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_s [2];
  logic [15:0] din_s   [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [15:0] dout_w  [2];
  logic [2:0]  sc_w    [2];

  int   cyc;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];

  four_value_sorter #(.DESCEND(1'b0)) u_asc (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_s[0]),
    .din        (din_s[0]),
    .busy       (busy_w[0]),
    .done       (done_w[0]),
    .dout       (dout_w[0]),
    .swap_count (sc_w[0])
  );

  four_value_sorter #(.DESCEND(1'b1)) u_desc (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_s[1]),
    .din        (din_s[1]),
    .busy       (busy_w[1]),
    .done       (done_w[1]),
    .dout       (dout_w[1]),
    .swap_count (sc_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input bit desc, input int k);
    exp_t e;
    int   v[$];
    int   mx;
    int   inv;
    int   c;
    mx  = 0;
    inv = 0;
    for (int i = 0; i < 4; i++) v.push_back(int'(d[4*i +: 4]));
    // bubble passes needed = most out-of-order predecessors of any element
    for (int i = 0; i < 4; i++) begin
      c = 0;
      for (int m = 0; m < i; m++)
        if (desc ? (v[m] < v[i]) : (v[m] > v[i])) c++;
      inv += c;
      if (c > mx) mx = c;
    end
    if (desc) v.rsort();
    else v.sort();
    e.dout = '0;
    for (int i = 0; i < 4; i++) e.dout[4*i +: 4] = v[i][3:0];
    e.sc = inv;
    e.n  = (mx == 0) ? 3 : (mx == 1) ? 5 : 6;
    e.k  = k;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (done_w[i]) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
              chk($sformatf("unexpected_done%0d", i), 1, 0);
            end else begin
              if (i == 0) e = q0.pop_front();
              else e = q1.pop_front();
              chk($sformatf("dout%0d", i), int'(dout_w[i]), int'(e.dout));
              chk($sformatf("swap_count%0d", i), int'(sc_w[i]), e.sc);
              chk($sformatf("latency%0d", i), cyc - e.k, e.n);
              chk($sformatf("busy_at_done%0d", i), int'(busy_w[i]), 1);
            end
          end
        end
      end
    end
  endtask

  // entered and left at posedge+#1 with the target DUT idle
  task automatic do_sort(input int idx, input logic [15:0] d,
                         input bit poke, input int gap);
    int t;
    exp_t e;
    chk($sformatf("idle_before%0d", idx), int'(busy_w[idx]), 0);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    start_s[idx] = 1'b1;
    din_s[idx]   = d;
    e = model(d, idx == 1, cyc + 1);
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
    @(posedge clk);
    #1;
    start_s[idx] = 1'b0;
    din_s[idx]   = 16'($urandom);
    chk($sformatf("busy_after_start%0d", idx), int'(busy_w[idx]), 1);
    if (poke) begin
      start_s[idx] = 1'b1;
      din_s[idx]   = ~d;
      @(posedge clk);
      #1;
      start_s[idx] = 1'b0;
    end
    t = 0;
    while (!done_w[idx] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk($sformatf("done_timeout%0d", idx), 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit saw;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      din_s[i]   = '0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
      chk($sformatf("rst_done%0d", i), int'(done_w[i]), 0);
      chk($sformatf("rst_dout%0d", i), int'(dout_w[i]), 0);
      chk($sformatf("rst_sc%0d", i), int'(sc_w[i]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset two cycles into a sort: discarded with no done pulse
    start_s[0] = 1'b1;
    din_s[0]   = 16'h05AF;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_w[0]), 0);
    chk("midrst_done", int'(done_w[0]), 0);
    chk("midrst_dout", int'(dout_w[0]), 0);
    chk("midrst_sc", int'(sc_w[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_w[0]) saw = 1'b1;
    end
    chk("no_done_after_rst", int'(saw), 0);
    @(posedge clk);
    #1;

    do_sort(0, 16'h4321, 1'b0, 0);
    do_sort(0, 16'h05AF, 1'b0, 0);
    do_sort(0, 16'h4312, 1'b0, 0);
    do_sort(0, 16'h7777, 1'b0, 1);
    do_sort(0, 16'h05AF, 1'b1, 0);
    do_sort(1, 16'h4321, 1'b0, 0);
    do_sort(1, 16'h1234, 1'b1, 0);
    for (int r = 0; r < 30; r++) begin
      do_sort(0, 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      do_sort(1, 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
